// File: rtl/mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// mux_tree_pipe
//
// Pipelined N:1 multiplexer tree of WIDTH-bit words with valid/ready at both
// ends. Tree level k pairs entries 2j/2j+1 of the previous level under sel[k].
// Missing odd partners and input indices >= N read as zero. A register stage
// follows every LEVELS_PER_STAGE levels, and the last stage is the output
// register, so the latency is S = ceil(clog2(N) / LEVELS_PER_STAGE) cycles.
// The whole pipeline advances together whenever the output register is empty
// or being consumed.
//
// Optional feature: define MUX_TREE_SEL_CHECK_EN to flag out-of-range selects
// (sel >= N). The flag travels with the word, appears on sel_err, and forces
// out_data to 0. Without the macro, sel_err is tied low and no flag is stored.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous, active-high, clears all state
//   in_valid   in   in_data/sel valid this cycle
//   in_ready   out  block accepts input this cycle (= pipeline advance)
//   sel        in   [SEL_W]   input index, bit 0 drives tree level 0
//   in_data    in   [N*WIDTH] input i at bits [i*WIDTH +: WIDTH]
//   out_valid  out  out_data valid
//   out_ready  in   downstream accepts out_data
//   out_data   out  [WIDTH]   selected word
//   sel_err    out  out-of-range select flag, qualified by out_valid
// -----------------------------------------------------------------------------
module mux_tree_pipe #(
  parameter  int WIDTH            = 64,
  parameter  int N                = 8,
  parameter  int LEVELS_PER_STAGE = 1,
  localparam int SEL_W            = $clog2(N)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SEL_W-1:0]   sel,
  input  logic [N*WIDTH-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               sel_err
);

  localparam int L = SEL_W;
  localparam int S = (L + LEVELS_PER_STAGE - 1) / LEVELS_PER_STAGE;

  // Stage registers. Each holds the partial data vector (entries past the
  // live count are always zero), the select bits still to be consumed
  // (shifted down so bit 0 drives the next level), and the valid bit.
  logic [N*WIDTH-1:0] data_d  [S];
  logic [N*WIDTH-1:0] data_q  [S];
  logic [SEL_W-1:0]   sel_d   [S];
  logic [SEL_W-1:0]   sel_q   [S];
  logic               valid_d [S];
  logic               valid_q [S];
`ifdef MUX_TREE_SEL_CHECK_EN
  logic               err_d   [S];
  logic               err_q   [S];
  logic               src_err;
`endif

  // Scratch for one stage's tree levels. The array is twice as deep as the
  // input count so that pairing entry 2j+1 never indexes past the end, and
  // the upper half stays zero, which provides the zero padding.
  logic [WIDTH-1:0]   cur [2*N];
  logic [WIDTH-1:0]   nxt [2*N];
  logic [N*WIDTH-1:0] src_data;
  logic [SEL_W-1:0]   src_sel;
  logic               src_valid;
  logic               advance;

  // Stall-all handshake: every stage moves only when the output register
  // is free or is being drained this cycle. This never depends on in_valid.
  assign advance  = !valid_q[S-1] || out_ready;
  assign in_ready = advance;

  // NOTE: combinational logic uses blocking assignments so that each
  // tree level reads the value the previous level just produced.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can leave one
    // unassigned and infer a latch.
    for (int s = 0; s < S; s++) begin
      data_d[s]  = '0;
      sel_d[s]   = '0;
      valid_d[s] = 1'b0;
`ifdef MUX_TREE_SEL_CHECK_EN
      err_d[s]   = 1'b0;
`endif
    end
    for (int i = 0; i < 2*N; i++) begin
      cur[i] = '0;
      nxt[i] = '0;
    end
    src_data  = in_data;
    src_sel   = sel;
    src_valid = in_valid;
`ifdef MUX_TREE_SEL_CHECK_EN
    src_err   = (32'(sel) >= 32'(N));
`endif

    for (int s = 0; s < S; s++) begin
      for (int i = 0; i < N; i++) cur[i] = src_data[i*WIDTH +: WIDTH];
      for (int i = N; i < 2*N; i++) cur[i] = '0;

      // The last group may hold fewer than LEVELS_PER_STAGE levels.
      for (int k = 0; k < LEVELS_PER_STAGE; k++) begin
        if (s*LEVELS_PER_STAGE + k < L) begin
          for (int j = 0; j < N; j++) nxt[j] = src_sel[0] ? cur[2*j+1] : cur[2*j];
          for (int j = N; j < 2*N; j++) nxt[j] = '0;
          cur     = nxt;
          src_sel = src_sel >> 1;
        end
      end

      for (int i = 0; i < N; i++) data_d[s][i*WIDTH +: WIDTH] = cur[i];
      sel_d[s]   = src_sel;
      valid_d[s] = src_valid;
`ifdef MUX_TREE_SEL_CHECK_EN
      err_d[s]   = src_err;
`endif

      // The next stage is fed from this stage's register.
      src_data  = data_q[s];
      src_sel   = sel_q[s];
      src_valid = valid_q[s];
`ifdef MUX_TREE_SEL_CHECK_EN
      src_err   = err_q[s];
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so that all stages
  // sample their predecessors' pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: data registers are reset along with the control bits because
      // out_data must read zero after reset, not just out_valid.
      for (int s = 0; s < S; s++) begin
        data_q[s]  <= '0;
        sel_q[s]   <= '0;
        valid_q[s] <= 1'b0;
`ifdef MUX_TREE_SEL_CHECK_EN
        err_q[s]   <= 1'b0;
`endif
      end
    end else if (advance) begin
      for (int s = 0; s < S; s++) begin
        data_q[s]  <= data_d[s];
        sel_q[s]   <= sel_d[s];
        valid_q[s] <= valid_d[s];
`ifdef MUX_TREE_SEL_CHECK_EN
        err_q[s]   <= err_d[s];
`endif
      end
    end
  end

  assign out_valid = valid_q[S-1];

`ifdef MUX_TREE_SEL_CHECK_EN
  assign sel_err  = valid_q[S-1] && err_q[S-1];
  assign out_data = err_q[S-1] ? '0 : data_q[S-1][WIDTH-1:0];
`else
  assign sel_err  = 1'b0;
  assign out_data = data_q[S-1][WIDTH-1:0];
`endif

endmodule

// File: tb/tb_mux_tree_pipe.sv
// -----------------------------------------------------------------------------
// tb_mux_tree_pipe
//
// Drives three instances of mux_tree_pipe together:
//   dut 0: N=8, WIDTH=8,  LEVELS_PER_STAGE=1  (S=3)
//   dut 1: N=5, WIDTH=16, LEVELS_PER_STAGE=2  (S=2)
//   dut 2: N=8, WIDTH=8,  LEVELS_PER_STAGE=4  (S=1)
// The reference model treats each instance as a delay line of S slots that
// moves only when its output slot is empty or consumed. The expected word is
// taken straight from the indexed input. The sel_err expectation follows
// MUX_TREE_SEL_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_mux_tree_pipe;

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        e;
  } ent_t;

`ifdef MUX_TREE_SEL_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        iv   [3];
  logic        ordy [3];
  logic [2:0]  sl   [3];
  logic [79:0] idat [3];

  logic        ir_a, ir_b, ir_c;
  logic        ov_a, ov_b, ov_c;
  logic        se_a, se_b, se_c;
  logic [7:0]  od_a, od_c;
  logic [15:0] od_b;

  ent_t mq0[$];
  ent_t mq1[$];
  ent_t mq2[$];

  int n_cmp;
  int n_bad;

  mux_tree_pipe #(.WIDTH(8), .N(8), .LEVELS_PER_STAGE(1)) u_a (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir_a), .sel(sl[0]),
    .in_data(idat[0][63:0]), .out_valid(ov_a), .out_ready(ordy[0]),
    .out_data(od_a), .sel_err(se_a)
  );

  mux_tree_pipe #(.WIDTH(16), .N(5), .LEVELS_PER_STAGE(2)) u_b (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir_b), .sel(sl[1]),
    .in_data(idat[1]), .out_valid(ov_b), .out_ready(ordy[1]),
    .out_data(od_b), .sel_err(se_b)
  );

  mux_tree_pipe #(.WIDTH(8), .N(8), .LEVELS_PER_STAGE(4)) u_c (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir_c), .sel(sl[2]),
    .in_data(idat[2][63:0]), .out_valid(ov_c), .out_ready(ordy[2]),
    .out_data(od_c), .sel_err(se_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int n_of(input int d);
    return (d == 1) ? 5 : 8;
  endfunction

  function automatic int w_of(input int d);
    return (d == 1) ? 16 : 8;
  endfunction

  function automatic int s_of(input int d);
    case (d)
      0:       return 3;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic ent_t get_out(input int d);
    ent_t o;
    case (d)
      0:       o = '{v: ov_a, d: {8'h00, od_a}, e: se_a};
      1:       o = '{v: ov_b, d: od_b,          e: se_b};
      default: o = '{v: ov_c, d: {8'h00, od_c}, e: se_c};
    endcase
    return o;
  endfunction

  function automatic logic get_ready(input int d);
    case (d)
      0:       return ir_a;
      1:       return ir_b;
      default: return ir_c;
    endcase
  endfunction

  function automatic ent_t head(input int d);
    case (d)
      0:       return mq0[0];
      1:       return mq1[0];
      default: return mq2[0];
    endcase
  endfunction

  // Expected slot contents for whatever the bench is presenting to dut d.
  function automatic ent_t expect_entry(input int d);
    ent_t        e;
    int          idx;
    logic [79:0] shifted;
    idx = int'(sl[d]);
    e.v = iv[d];
    e.e = CHK && (idx >= n_of(d));
    e.d = '0;
    if (idx < n_of(d)) begin
      shifted = idat[d] >> (idx * w_of(d));
      e.d = (w_of(d) == 8) ? {8'h00, shifted[7:0]} : shifted[15:0];
    end
    return e;
  endfunction

  task automatic model_push(input int d, input ent_t e);
    case (d)
      0:       begin mq0.push_back(e); void'(mq0.pop_front()); end
      1:       begin mq1.push_back(e); void'(mq1.pop_front()); end
      default: begin mq2.push_back(e); void'(mq2.pop_front()); end
    endcase
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    mq2.delete();
    repeat (s_of(0)) mq0.push_back('0);
    repeat (s_of(1)) mq1.push_back('0);
    repeat (s_of(2)) mq2.push_back('0);
  endtask

  // Called just after a falling edge with inputs already driven. It checks
  // in_ready, steps the model across the next rising edge, and checks the
  // outputs at the following falling edge.
  task automatic step();
    ent_t h;
    ent_t o;
    logic adv;
    #1;
    for (int d = 0; d < 3; d++) begin
      h   = head(d);
      adv = !h.v || ordy[d];
      check($sformatf("in_ready%0d", d), 32'(get_ready(d)), 32'(adv));
      if (adv) model_push(d, expect_entry(d));
    end
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      h = head(d);
      o = get_out(d);
      check($sformatf("out_valid%0d", d), 32'(o.v), 32'(h.v));
      if (h.v) begin
        check($sformatf("out_data%0d", d), 32'(o.d), 32'(h.d));
        check($sformatf("sel_err%0d", d), 32'(o.e), 32'(h.e));
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    ent_t o;
    for (int d = 0; d < 3; d++) begin
      o = get_out(d);
      check($sformatf("%s_valid%0d", tag, d), 32'(o.v), 32'd0);
      check($sformatf("%s_data%0d", tag, d),  32'(o.d), 32'd0);
      check($sformatf("%s_err%0d", tag, d),   32'(o.e), 32'd0);
    end
  endtask

  // Single-word pulse into dut d. Measures cycles until out_valid (bounded),
  // then checks the word and its error flag against fixed values.
  task automatic pulse_latency(input int d, input logic [2:0] s, input int exp_lat,
                               input logic [15:0] exp_data, input logic exp_err);
    int   lat;
    ent_t o;
    iv[d] = 1'b1;
    sl[d] = s;
    step();
    iv[d] = 1'b0;
    lat   = 1;
    o     = get_out(d);
    while (!o.v && lat < 10) begin
      step();
      lat++;
      o = get_out(d);
    end
    check($sformatf("latency%0d_sel%0d", d, s), 32'(lat), 32'(exp_lat));
    check($sformatf("pulse_data%0d_sel%0d", d, s), 32'(o.d), 32'(exp_data));
    check($sformatf("pulse_err%0d_sel%0d", d, s), 32'(o.e), 32'(exp_err));
    step();
  endtask

  initial begin
    logic [2:0] b2b [4];
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    for (int d = 0; d < 3; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b1;
      sl[d]   = '0;
      idat[d] = '0;
    end
    model_reset();

    // Reset state.
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      idat[0][i*8 +: 8] = 8'h10 + 8'(i);
      idat[2][i*8 +: 8] = 8'h10 + 8'(i);
    end
    for (int i = 0; i < 5; i++) idat[1][i*16 +: 16] = 16'hB000 + 16'(i);

    // Latency and single-word selection on each configuration.
    pulse_latency(0, 3'd5, 3, 16'h0015, 1'b0);
    pulse_latency(2, 3'd7, 1, 16'h0017, 1'b0);
    pulse_latency(1, 3'd4, 2, 16'hB004, 1'b0);
    pulse_latency(1, 3'd6, 2, 16'h0000, CHK);
    pulse_latency(1, 3'd1, 2, 16'hB001, 1'b0);
    pulse_latency(1, 3'd7, 2, 16'h0000, CHK);
    pulse_latency(1, 3'd5, 2, 16'h0000, CHK);

    // Back-to-back words at full throughput.
    b2b[0] = 3'd0;
    b2b[1] = 3'd7;
    b2b[2] = 3'd3;
    b2b[3] = 3'd6;
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1'b1;
      sl[0] = b2b[i];
      step();
    end
    iv[0] = 1'b0;
    repeat (4) step();

    // Backpressure: hold the output word, then drain it and its follower.
    iv[0] = 1'b1;
    sl[0] = 3'd2;
    step();
    sl[0] = 3'd4;
    step();
    iv[0] = 1'b0;
    step();
    ordy[0] = 1'b0;
    repeat (4) step();
    check("stall_data", 32'(od_a), 32'h12);
    check("stall_ready", 32'(ir_a), 32'd0);
    ordy[0] = 1'b1;
    repeat (3) step();

    // Asynchronous reset with words in flight.
    for (int d = 0; d < 3; d++) iv[d] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int d = 0; d < 3; d++) sl[d] = 3'($urandom_range(0, 4));
      step();
    end
    for (int d = 0; d < 3; d++) iv[d] = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_idle_outputs("async_reset");
    check("async_reset_ready", 32'(ir_a), 32'd1);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    // Accept in the same cycle reset is released.
    iv[0] = 1'b1;
    sl[0] = 3'd1;
    step();
    iv[0] = 1'b0;
    repeat (5) step();

    // Randomized traffic with random backpressure and out-of-range selects.
    repeat (400) begin
      for (int d = 0; d < 3; d++) begin
        iv[d]   = ($urandom_range(0, 9) < 7);
        ordy[d] = ($urandom_range(0, 9) < 7);
        sl[d]   = 3'($urandom_range(0, 7));
        idat[d] = {16'($urandom), 32'($urandom), 32'($urandom)};
      end
      step();
    end

    for (int d = 0; d < 3; d++) begin
      iv[d]   = 1'b0;
      ordy[d] = 1'b1;
    end
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_tree_pipe.md
Name: mux_tree_pipe

Overview:
- Parametrised, pipelined N:1 multiplexer tree of WIDTH-bit words with a valid/ready handshake at both ends.
- Generalises the fixed 8:1 single-bit mux to arbitrary input count and word width.
- Registers are inserted every LEVELS_PER_STAGE tree levels so wide operand/forwarding selects in the core's datapath close timing.
- Carries select bits down the pipe and stalls cleanly under backpressure.

Parameters:
WIDTH, 64, bits per data word (>=1)
N, 8, number of inputs (>=2, need not be a power of two)
LEVELS_PER_STAGE, 1, 2:1 tree levels between pipeline registers (>=1)
(derived) SEL_W = clog2(N); L = SEL_W tree levels; S = ceil(L/LEVELS_PER_STAGE) register stages

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high; clears all state immediately
in_valid  input  1  input word set and sel valid this cycle
in_ready  output  1  block accepts input this cycle
sel  input  SEL_W  input index; bit 0 drives tree level 0
in_data  input  N*WIDTH  input i at bits [i*WIDTH +: WIDTH]
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_data  output  WIDTH  selected word
sel_err  output  1  out-of-range select flag (see Optional Feature)

Behaviour:
- Tree structure: level k (0-based) pairs entries 2j and 2j+1 of the previous level, selected by sel[k]. If a level has an odd count, the missing odd partner is zero. Input indices >= N read as zero.
- Pipeline: a register stage follows each group of LEVELS_PER_STAGE levels; the last group ends in the output register.
- Each stage register holds the partial data vector, remaining sel bits, a valid bit, and an err bit.
- Latency is exactly S cycles from an accepted input to out_valid, with no stall. N=8, LPS=1 gives 3; N=8, LPS>=3 gives 1.
- Handshake uses a stall-all pipeline: advance = !out_valid || out_ready.
  - in_ready = advance, combinational from out_valid/out_ready only, never from in_valid.
  - When advance=1, every stage loads from its predecessor; stage 0 loads in_valid/in_data/sel.
  - When advance=0, all stages hold, including bubbles.
- Input is accepted when in_valid && in_ready.
- Output is consumed when out_valid && out_ready.
- out_data and sel_err stay stable while out_valid=1 && out_ready=0.
- Throughput: one word per cycle when out_ready is held high.
- Bubbles: in_valid=0 on an advance cycle inserts a bubble (valid=0). Data registers of a bubble may load but must not be relied on.
- Reset values: all valid bits 0, all data registers 0, all carried sel bits 0, all err bits 0. Therefore out_valid=0, out_data=0, sel_err=0 after reset.
- Reset asserted mid-operation discards all in-flight words; no partial output appears after release.
- First accept after reset is possible in the cycle reset deasserts, since in_ready=1 when out_valid=0.
- Simultaneous consume and accept in one cycle is allowed; the pipeline shifts by one.

Optional Feature:
- Macro MUX_TREE_SEL_CHECK_EN.
- Defined:
  - On accept, sel >= N sets that entry's err bit, which travels with the word.
  - sel_err = err bit of the output stage, valid only with out_valid.
  - out_data for such a word is forced to 0.
- Undefined:
  - sel_err is tied 0.
  - Out-of-range sel yields the zero-padded tree result, which is also 0.
  - No err storage exists.

Test Plan:
1. N=8, WIDTH=8, LPS=1, out_ready=1; in_data[i]=8'h10+i, sel=5, one pulse -> out_valid exactly 3 cycles later with out_data=8'h15, then out_valid=0.
2. Back-to-back sel=0,7,3,6 on 4 consecutive cycles, out_ready=1 -> out_data 8'h10,8'h17,8'h13,8'h16 on 4 consecutive cycles starting at latency 3.
3. Output valid with sel=2, out_ready=0 for 4 cycles -> in_ready=0, out_data holds 8'h12; out_ready=1 -> consumed, next queued word follows the next cycle.
4. N=5, WIDTH=16, LPS=2 (S=2), macro defined; sel=4 -> out_data=in[4]; sel=6 -> out_data=0, sel_err=1; sel=1 -> sel_err=0.
5. Three words in flight, reset pulsed asynchronously mid-cycle -> out_valid=0, out_data=0, sel_err=0 immediately; no stale word emerges after release.
6. N=8, LPS=4 -> latency 1; sel=7 -> out_data=in[7] on the next cycle.
